// File: rtl/note_frame_scheduler.sv
// note_frame_scheduler: per-beat sequencer that erases every lit note cell, shifts the
// notes register down one row, then redraws every lit cell through the plotter handshake.
module note_frame_scheduler #(
    parameter int         LANES   = 5,
    parameter int         ROWS    = 8,
    parameter logic [8:0] LANE_X0 = 9'd100,
    parameter logic [8:0] X_PITCH = 9'd24,
    parameter logic [7:0] Y0      = 8'd16,
    parameter logic [7:0] Y_PITCH = 8'd28
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             beat,
    input  logic             run,
    input  logic [LANES-1:0] row_data,
    output logic [2:0]       row_sel,
    output logic             shift,
    output logic             cell_req,
    output logic [8:0]       cell_x,
    output logic [7:0]       cell_y,
    output logic [2:0]       cell_lane,
    output logic             cell_erase,
    input  logic             cell_ack,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       missed_beats
);
    typedef enum logic [2:0] {
        IDLE, ERASE_SCAN, ERASE_WAIT, SHIFT, SETTLE, DRAW_SCAN, DRAW_WAIT, DONE
    } state_t;

    state_t     state, state_next;
    logic [2:0] lane, row;
    logic       last_lane, last_cell, lit, advance, capture;

    assign last_lane = lane == 3'(LANES - 1);
    assign last_cell = last_lane && row == 3'(ROWS - 1);
    assign lit       = row_data[lane];

    always_comb begin
        state_next = state;
        advance    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: state_next = beat && run ? ERASE_SCAN : IDLE;
            ERASE_SCAN, DRAW_SCAN: begin
                capture = lit;
                advance = !lit;
                if (lit)
                    state_next = state == ERASE_SCAN ? ERASE_WAIT : DRAW_WAIT;
                else if (last_cell)
                    state_next = state == ERASE_SCAN ? SHIFT : DONE;
            end
            ERASE_WAIT, DRAW_WAIT: begin
                advance = cell_ack;
                if (cell_ack && last_cell)
                    state_next = state == ERASE_WAIT ? SHIFT : DONE;
                else if (cell_ack)
                    state_next = state == ERASE_WAIT ? ERASE_SCAN : DRAW_SCAN;
            end
            SHIFT:   state_next = SETTLE;
            SETTLE:  state_next = DRAW_SCAN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The index wraps to row 0 after the last cell, so SHIFT/SETTLE present row 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            lane         <= 3'd0;
            row          <= 3'd0;
            cell_x       <= 9'd0;
            cell_y       <= 8'd0;
            cell_lane    <= 3'd0;
            cell_erase   <= 1'b0;
            missed_beats <= 8'd0;
        end else begin
            state <= state_next;
            if (advance) begin
                lane <= last_lane ? 3'd0 : lane + 3'd1;
                row  <= last_cell ? 3'd0 : last_lane ? row + 3'd1 : row;
            end
            if (capture) begin
                cell_x     <= LANE_X0 + X_PITCH * {6'd0, lane};
                cell_y     <= Y0 + Y_PITCH * {5'd0, row};
                cell_lane  <= lane;
                cell_erase <= state == ERASE_SCAN;
            end
            if (beat && state != IDLE && missed_beats != 8'hff)
                missed_beats <= missed_beats + 8'd1;
        end
    end

    assign row_sel    = row;
    assign cell_req   = state == ERASE_WAIT || state == DRAW_WAIT;
    assign shift      = state == SHIFT;
    assign busy       = state != IDLE;
    assign frame_done = state == DONE;
endmodule

// File: tb/tb_note_frame_scheduler.sv
// tb_note_frame_scheduler: random grids and plotter latencies checked against a
// cell-list / cycle-count model of one frame.
module tb_note_frame_scheduler;
    logic       clk = 1'b0, resetn = 1'b0, beat = 1'b0, run = 1'b0, cell_ack = 1'b0;
    logic [4:0] row_data;
    logic [2:0] row_sel, cell_lane;
    logic       shift, cell_req, cell_erase, busy, frame_done;
    logic [8:0] cell_x;
    logic [7:0] cell_y, missed_beats;
    logic [4:0] grid [8];
    logic [4:0] new_top;
    int         n_chk = 0, n_pass = 0, exp_missed = 0;

    always #10 clk = ~clk;
    assign row_data = grid[row_sel];

    note_frame_scheduler dut (
        .clk(clk), .resetn(resetn), .beat(beat), .run(run), .row_data(row_data),
        .row_sel(row_sel), .shift(shift), .cell_req(cell_req), .cell_x(cell_x),
        .cell_y(cell_y), .cell_lane(cell_lane), .cell_erase(cell_erase),
        .cell_ack(cell_ack), .busy(busy), .frame_done(frame_done),
        .missed_beats(missed_beats)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_row_sel"}, row_sel, 0);
        check({pfx, "_shift"}, shift, 0);
        check({pfx, "_cell_req"}, cell_req, 0);
        check({pfx, "_cell_x"}, cell_x, 0);
        check({pfx, "_cell_y"}, cell_y, 0);
        check({pfx, "_cell_lane"}, cell_lane, 0);
        check({pfx, "_cell_erase"}, cell_erase, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_frame_done"}, frame_done, 0);
        check({pfx, "_missed"}, missed_beats, exp_missed);
    endtask

    // One frame: expected erase list from the current grid, draw list from the shifted
    // grid; frame length = empty-grid length plus the request-high cycles of each cell.
    task automatic run_frame(input int dmin, input int dmax, input int beat_period,
                             input bit beat_at_done, input bit drop_run);
        int         ex[$], ey[$], el[$], ee[$];
        logic [4:0] nxt [8];
        int         n_erase, bound, sum_e = 0, sum_d = 0, c = 1, t_shift = -1, t_done = -1;
        int         idx = 0, wait_cnt = 0, delay = 0;
        bit         prev_req = 0, prev_ack = 0;
        nxt[0] = new_top;
        for (int r = 1; r < 8; r++) nxt[r] = grid[r-1];
        for (int r = 0; r < 8; r++)
            for (int l = 0; l < 5; l++)
                if (grid[r][l]) begin
                    ex.push_back(100 + 24 * l); ey.push_back(16 + 28 * r);
                    el.push_back(l); ee.push_back(1);
                end
        n_erase = ex.size();
        for (int r = 0; r < 8; r++)
            for (int l = 0; l < 5; l++)
                if (nxt[r][l]) begin
                    ex.push_back(100 + 24 * l); ey.push_back(16 + 28 * r);
                    el.push_back(l); ee.push_back(0);
                end
        bound = 200 + 80 * (dmax + 2);
        @(negedge clk);
        beat = 1; run = 1;
        @(negedge clk);
        while (t_done < 0 && c < bound) begin
            beat = 0; cell_ack = 0;
            if (prev_ack) check("req_low_after_ack", cell_req, 0);
            if (cell_req && (!prev_req || prev_ack)) begin
                if (idx < ex.size()) begin
                    check("cell_x", cell_x, ex[idx]);
                    check("cell_y", cell_y, ey[idx]);
                    check("cell_lane", cell_lane, el[idx]);
                    check("cell_erase", cell_erase, ee[idx]);
                    delay = $urandom_range(dmax, dmin);
                    if (idx < n_erase) sum_e += delay + 1;
                    else sum_d += delay + 1;
                end else check("req_count", idx + 1, ex.size());
                idx++;
                wait_cnt = 0;
            end
            if (cell_req) begin
                if (wait_cnt == delay) cell_ack = 1;
                wait_cnt++;
            end
            if (shift) begin
                t_shift = c;
                grid = nxt;
            end
            if (frame_done) t_done = c;
            if (drop_run && c == 10) run = 0;
            if ((beat_period > 0 && c % beat_period == 0) || (frame_done && beat_at_done)) begin
                beat = 1;
                exp_missed = exp_missed < 255 ? exp_missed + 1 : 255;
            end
            prev_req = cell_req;
            prev_ack = cell_ack;
            @(negedge clk);
            c++;
        end
        beat = 0; cell_ack = 0;
        check("cell_count", idx, ex.size());
        check("shift_cycle", t_shift, 41 + sum_e);
        check("done_cycle", t_done, 83 + sum_e + sum_d);
        check("busy_after_done", busy, 0);
        check("missed_beats", missed_beats, exp_missed);
        run = 1;
    endtask

    initial begin
        bit found = 0;
        for (int r = 0; r < 8; r++) grid[r] = 5'd0;
        new_top = 5'd0;
        #5 check_zero("in_reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        check_zero("post_reset");
        run_frame(0, 0, 0, 0, 0);
        grid[0] = 5'b00001;
        run_frame(2, 2, 0, 0, 0);
        for (int r = 0; r < 8; r++) grid[r] = 5'h1f;
        new_top = 5'h1f;
        run_frame(0, 0, 0, 0, 0);
        run = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); beat = 1;
            @(negedge clk); beat = 0;
            check("idle_when_run0", busy, 0);
        end
        check("missed_run0", missed_beats, exp_missed);
        run = 1;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 8; r++) grid[r] = 5'($urandom_range(0, 31));
            new_top = 5'($urandom_range(0, 31));
            run_frame(0, 3, (k % 2) ? 7 : 0, k % 3 == 0, k == 5);
        end
        run_frame(0, 1, 13, 1, 1);
        for (int r = 0; r < 8; r++) grid[r] = 5'd0;
        grid[0] = 5'b00001;
        new_top = 5'd0;
        run_frame(3000, 3000, 20, 0, 0);
        check("missed_saturated", missed_beats, 255);
        for (int r = 0; r < 8; r++) grid[r] = 5'd0;
        grid[0] = 5'b00001;
        @(negedge clk);
        beat = 1;
        @(negedge clk);
        beat = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cell_ack = cell_req && cell_erase;
            if (cell_req && !cell_erase) found = 1;
            else @(negedge clk);
        end
        check("reached_draw_wait", found, 1);
        #2 resetn = 0;
        exp_missed = 0;
        #1 check_zero("async_reset");
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        cell_ack = 1;
        @(negedge clk);
        cell_ack = 0;
        check_zero("stray_ack");
        @(negedge clk);
        check("busy_after_stray", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
